// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_if
// Brief    : Upstream instruction handshake and ALU-side outputs of the issue stage.
// Revision : 1.0
// ============================================================================
interface alu_issue_stage_if #(
    parameter int DEPTH = 4
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic [31:0]        in_pc;
    logic [31:0]        in_rs1;
    logic [31:0]        in_rs2;
    logic               stall;
    logic               flush;
    logic [4:0]         aluop;
    logic [31:0]        aluin1;
    logic [31:0]        aluin2;
    logic               issue_valid;
    logic               res_valid;
    logic [4:0]         res_rd;
    logic               res_illegal;
    logic [c_cnt_w-1:0] count;

    modport master (
        output in_valid, in_instr, in_pc, in_rs1, in_rs2, stall, flush,
        input  in_ready, aluop, aluin1, aluin2, issue_valid,
               res_valid, res_rd, res_illegal, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1, in_rs2, stall, flush,
        output in_ready, aluop, aluin1, aluin2, issue_valid,
               res_valid, res_rd, res_illegal, count
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : RV32IM decode into ALU op/operands, FIFO buffering, registered
//            issue and a one-stage result tag pipeline aligned with aluout.
// Revision : 1.0
// ============================================================================
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   bus
);
    localparam int         c_ptr_w      = $clog2(DEPTH);
    localparam int         c_cnt_w      = $clog2(DEPTH + 1);
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    function automatic logic [4:0] f_base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return 5'd0;
            3'b001:  return 5'd2;
            3'b010:  return 5'd8;
            3'b011:  return 5'd9;
            3'b100:  return 5'd3;
            3'b101:  return 5'd4;
            3'b110:  return 5'd6;
            default: return 5'd7;
        endcase
    endfunction

    function automatic logic [4:0] f_mext_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return 5'd22;
            3'b001:  return 5'd16;
            3'b010:  return 5'd17;
            3'b011:  return 5'd18;
            3'b100:  return 5'd24;
            3'b101:  return 5'd26;
            3'b110:  return 5'd28;
            default: return 5'd30;
        endcase
    endfunction

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic [31:0]        w_shamt;
    logic [4:0]         w_dec_op;
    logic [31:0]        w_dec_a;
    logic [31:0]        w_dec_b;
    logic               w_dec_ill;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;

    entry_t             r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [4:0]         r_aluop;
    logic [31:0]        r_aluin1;
    logic [31:0]        r_aluin2;
    logic [4:0]         r_iss_rd;
    logic               r_iss_ill;
    logic               r_issue_valid;
    logic               r_res_valid;
    logic [4:0]         r_res_rd;
    logic               r_res_illegal;

    assign w_opcode = bus.in_instr[6:0];
    assign w_funct3 = bus.in_instr[14:12];
    assign w_funct7 = bus.in_instr[31:25];
    assign w_shamt  = {27'b0, bus.in_instr[24:20]};

    always_comb begin
        w_dec_op  = 5'd0;
        w_dec_a   = '0;
        w_dec_b   = '0;
        w_dec_ill = 1'b1;
        case (w_opcode)
            c_opc_op: begin
                w_dec_a = bus.in_rs1;
                w_dec_b = bus.in_rs2;
                case (w_funct7)
                    7'b0000000: begin
                        w_dec_op  = f_base_op(w_funct3);
                        w_dec_ill = 1'b0;
                    end
                    7'b0100000: begin
                        if (w_funct3 == 3'b000) begin
                            w_dec_op  = 5'd1;
                            w_dec_ill = 1'b0;
                        end else if (w_funct3 == 3'b101) begin
                            w_dec_op  = 5'd5;
                            w_dec_ill = 1'b0;
                        end
                    end
                    7'b0000001: begin
                        w_dec_op  = f_mext_op(w_funct3);
                        w_dec_ill = 1'b0;
                    end
                    default: ;
                endcase
            end
            c_opc_op_imm: begin
                w_dec_a   = bus.in_rs1;
                w_dec_b   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
                w_dec_op  = f_base_op(w_funct3);
                w_dec_ill = 1'b0;
                // Shift-immediates reuse the upper immediate bits as funct7
                if (w_funct3 == 3'b001) begin
                    w_dec_b   = w_shamt;
                    w_dec_ill = (w_funct7 != 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_dec_b = w_shamt;
                    if (w_funct7 == 7'b0100000) begin
                        w_dec_op = 5'd5;
                    end else if (w_funct7 != 7'b0000000) begin
                        w_dec_ill = 1'b1;
                    end
                end
            end
            c_opc_lui: begin
                w_dec_b   = {bus.in_instr[31:12], 12'b0};
                w_dec_ill = 1'b0;
            end
            c_opc_auipc: begin
                w_dec_a   = bus.in_pc;
                w_dec_b   = {bus.in_instr[31:12], 12'b0};
                w_dec_ill = 1'b0;
            end
            default: ;
        endcase
        if (w_dec_ill) begin
            w_dec_op = 5'd0;
            w_dec_a  = '0;
            w_dec_b  = '0;
        end
    end

    assign w_full   = (r_count == c_cnt_w'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop    = !w_empty && !bus.stall && !bus.flush;
    assign w_head   = r_mem[r_rd_ptr];

    // Storage carries no reset: validity is tracked entirely by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{op: w_dec_op, a: w_dec_a, b: w_dec_b,
                                 rd: bus.in_instr[11:7], ill: w_dec_ill};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_aluop       <= '0;
            r_aluin1      <= '0;
            r_aluin2      <= '0;
            r_iss_rd      <= '0;
            r_iss_ill     <= 1'b0;
            r_issue_valid <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_rd      <= '0;
            r_res_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_issue_valid <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_illegal <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_w'(1);
                r_aluop   <= w_head.op;
                r_aluin1  <= w_head.a;
                r_aluin2  <= w_head.b;
                r_iss_rd  <= w_head.rd;
                r_iss_ill <= w_head.ill;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            r_issue_valid <= w_pop;
            r_res_valid   <= r_issue_valid;
            r_res_rd      <= r_iss_rd;
            r_res_illegal <= r_issue_valid && r_iss_ill;
        end
    end

    assign bus.in_ready    = !w_full && !rst;
    assign bus.aluop       = r_aluop;
    assign bus.aluin1      = r_aluin1;
    assign bus.aluin2      = r_aluin2;
    assign bus.issue_valid = r_issue_valid;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_rd      = r_res_rd;
    assign bus.res_illegal = r_res_illegal;
    assign bus.count       = r_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Directed self-checking bench for alu_issue_stage (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_alu_issue_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_issue_stage_if #(.DEPTH(4)) bus ();

    alu_issue_stage #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.stall = 1'b0; bus.flush = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.aluop, bus.aluin1, bus.aluin2, bus.res_rd} !== 74'd0) begin
            errors++;
            $display("FAIL reset_regs: got op=%0d a=%h b=%h rd=%0d, required all 0",
                     bus.aluop, bus.aluin1, bus.aluin2, bus.res_rd);
        end
        checks++;
        if ({bus.issue_valid, bus.res_valid, bus.res_illegal} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valids: got %b, required 000",
                     {bus.issue_valid, bus.res_valid, bus.res_illegal});
        end
        checks++;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", bus.count);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b, required 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        bus.in_valid = 1'b1;
        bus.in_instr = enc_r(7'h00, 3'b000, 5'd5);
        bus.in_rs1   = 32'd7;
        bus.in_rs2   = 32'd3;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL basic_no_bypass: got iv=%b count=%0d, required iv=0 count=1",
                     bus.issue_valid, bus.count);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2} !== {1'b1, 5'd0, 32'd7, 32'd3}) begin
            errors++;
            $display("FAIL basic_issue: got iv=%b op=%0d a=%0d b=%0d, required iv=1 op=0 a=7 b=3",
                     bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.res_rd, bus.issue_valid} !== {1'b1, 5'd5, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got rv=%b rd=%0d iv=%b, required rv=1 rd=5 iv=0",
                     bus.res_valid, bus.res_rd, bus.issue_valid);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_result_drop: got rv=%b, required 0", bus.res_valid);
        end
    endtask

    task automatic test_decode();
        logic [4:0] rt_code [8] = '{5'd0, 5'd2, 5'd8, 5'd9, 5'd3, 5'd4, 5'd6, 5'd7};
        logic [4:0] m_code  [8] = '{5'd22, 5'd16, 5'd17, 5'd18, 5'd24, 5'd26, 5'd28, 5'd30};
        logic [6:0] f7s     [3] = '{7'h00, 7'h20, 7'h01};
        vec_t vq[$];
        vec_t v;
        logic [31:0] ra;
        logic [31:0] rb;
        ra = 32'h1111_0007;
        rb = 32'h2222_0003;
        for (int j = 0; j < 3; j++) begin
            for (int f = 0; f < 8; f++) begin
                v.instr = enc_r(f7s[j], 3'(f), 5'(8 + f + j));
                v.pc = 32'h40; v.rs1 = ra; v.rs2 = rb;
                v.rd = 5'(8 + f + j); v.a = ra; v.b = rb; v.ill = 1'b0;
                if (j == 0) v.op = rt_code[f];
                else if (j == 2) v.op = m_code[f];
                else if (f == 0) v.op = 5'd1;
                else if (f == 5) v.op = 5'd5;
                else begin
                    v.op = 5'd0; v.a = '0; v.b = '0; v.ill = 1'b1;
                end
                vq.push_back(v);
            end
        end
        vq.push_back('{32'h4052_5193, 32'h0, 32'h8000_0000, 32'h5, 5'd5, 32'h8000_0000, 32'd5, 5'd3, 1'b0});
        vq.push_back('{32'hFFF0_8313, 32'h0, 32'd7, 32'h9, 5'd0, 32'd7, 32'hFFFF_FFFF, 5'd6, 1'b0});
        vq.push_back('{32'h1234_53B7, 32'h0, 32'h55, 32'h66, 5'd0, 32'h0, 32'h1234_5000, 5'd7, 1'b0});
        vq.push_back('{32'h0000_1497, 32'h100, 32'h55, 32'h66, 5'd0, 32'h100, 32'h0000_1000, 5'd9, 1'b0});
        for (int i = 0; i < vq.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = vq[i].instr; bus.in_pc = vq[i].pc;
            bus.in_rs1 = vq[i].rs1; bus.in_rs2 = vq[i].rs2;
            tick();
            bus.in_valid = 1'b0;
            tick();
            checks++;
            if ({bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2} !==
                {1'b1, vq[i].op, vq[i].a, vq[i].b}) begin
                errors++;
                $display("FAIL decode_issue[%0d] instr=%h: got iv=%b op=%0d a=%h b=%h, required iv=1 op=%0d a=%h b=%h",
                         i, vq[i].instr, bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2,
                         vq[i].op, vq[i].a, vq[i].b);
            end
            tick();
            checks++;
            if ({bus.res_valid, bus.res_rd, bus.res_illegal} !== {1'b1, vq[i].rd, vq[i].ill}) begin
                errors++;
                $display("FAIL decode_result[%0d]: got rv=%b rd=%0d ill=%b, required rv=1 rd=%0d ill=%b",
                         i, bus.res_valid, bus.res_rd, bus.res_illegal, vq[i].rd, vq[i].ill);
            end
        end
        tick();
    endtask

    task automatic test_illegal();
        vec_t vq[2];
        vq[0] = '{32'h0000_007F, 32'h200, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1};
        vq[1] = '{enc_r(7'h20, 3'b000, 5'd12), 32'h204, 32'd50, 32'd8, 5'd1, 32'd50, 32'd8, 5'd12, 1'b0};
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = vq[i].instr; bus.in_pc = vq[i].pc;
            bus.in_rs1 = vq[i].rs1; bus.in_rs2 = vq[i].rs2;
            tick();
            bus.in_valid = 1'b0;
            tick();
            checks++;
            if ({bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2} !==
                {1'b1, vq[i].op, vq[i].a, vq[i].b}) begin
                errors++;
                $display("FAIL illegal_issue[%0d]: got iv=%b op=%0d a=%h b=%h, required iv=1 op=%0d a=%h b=%h",
                         i, bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2,
                         vq[i].op, vq[i].a, vq[i].b);
            end
            tick();
            checks++;
            if ({bus.res_valid, bus.res_rd, bus.res_illegal} !== {1'b1, vq[i].rd, vq[i].ill}) begin
                errors++;
                $display("FAIL illegal_result[%0d]: got rv=%b rd=%0d ill=%b, required rv=1 rd=%0d ill=%b",
                         i, bus.res_valid, bus.res_rd, bus.res_illegal, vq[i].rd, vq[i].ill);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = enc_r(7'h00, 3'b000, 5'(i + 1));
            bus.in_rs1 = 32'(100 + i);
            bus.in_rs2 = 32'(i);
            if (i < 4) tick();
        end
        checks++;
        if ({bus.count, bus.in_ready, bus.issue_valid} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_hold: got count=%0d ready=%b iv=%b, required count=4 ready=0 iv=0",
                     bus.count, bus.in_ready, bus.issue_valid);
        end
        bus.stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) bus.in_valid = 1'b0;
            checks++;
            if ({bus.issue_valid, bus.aluin1, bus.res_rd} !==
                {1'b1, 32'(100 + k), (k == 0) ? bus.res_rd : 5'(k)}) begin
                errors++;
                $display("FAIL b2b_issue[%0d]: got iv=%b a=%0d res_rd=%0d, required iv=1 a=%0d",
                         k, bus.issue_valid, bus.aluin1, bus.res_rd, 100 + k);
            end
            checks++;
            if (bus.count !== ((k < 2) ? 3'd3 : 3'(4 - k))) begin
                errors++;
                $display("FAIL b2b_count[%0d]: got %0d, required %0d",
                         k, bus.count, (k < 2) ? 3 : 4 - k);
            end
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.res_valid, bus.res_rd} !== {1'b0, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL b2b_drain: got iv=%b rv=%b rd=%0d, required iv=0 rv=1 rd=5",
                     bus.issue_valid, bus.res_valid, bus.res_rd);
        end
        tick();
    endtask

    task automatic test_flush();
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = enc_r(7'h00, 3'b110, 5'(20 + i));
            bus.in_rs1 = 32'(200 + i);
            bus.in_rs2 = 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.stall = 1'b0;
        tick();
        checks++;
        if ({bus.issue_valid, bus.count, bus.aluin1} !== {1'b1, 3'd3, 32'd200}) begin
            errors++;
            $display("FAIL flush_setup: got iv=%b count=%0d a=%0d, required iv=1 count=3 a=200",
                     bus.issue_valid, bus.count, bus.aluin1);
        end
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.count, bus.issue_valid, bus.res_valid} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_clear: got count=%0d iv=%b rv=%b, required 0 0 0",
                     bus.count, bus.issue_valid, bus.res_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.count, bus.issue_valid, bus.res_valid} !== {3'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL flush_stale[%0d]: got count=%0d iv=%b rv=%b, required 0 0 0",
                         k, bus.count, bus.issue_valid, bus.res_valid);
            end
        end
    endtask

    task automatic test_reset_midop();
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = enc_r(7'h01, 3'b000, 5'(24 + i));
            bus.in_rs1 = 32'(300 + i);
            bus.in_rs2 = 32'd9;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.stall = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.issue_valid, bus.res_valid, bus.count} !== {1'b1, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL rst_setup: got iv=%b rv=%b count=%0d, required 1 1 2",
                     bus.issue_valid, bus.res_valid, bus.count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.aluop, bus.aluin1, bus.aluin2, bus.res_rd, bus.issue_valid, bus.res_valid,
             bus.res_illegal, bus.count, bus.in_ready} !== 81'd0) begin
            errors++;
            $display("FAIL rst_async: got op=%0d a=%0d b=%0d rd=%0d iv=%b rv=%b ill=%b count=%0d ready=%b, required all 0",
                     bus.aluop, bus.aluin1, bus.aluin2, bus.res_rd, bus.issue_valid,
                     bus.res_valid, bus.res_illegal, bus.count, bus.in_ready);
        end
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = enc_r(7'h00, 3'b100, 5'd17);
        bus.in_rs1 = 32'hF0F0_0000;
        bus.in_rs2 = 32'h0F0F_0001;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.issue_valid, bus.res_valid, bus.count} !== {1'b0, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL rst_after_e0: got iv=%b rv=%b count=%0d, required 0 0 1",
                     bus.issue_valid, bus.res_valid, bus.count);
        end
        tick();
        checks++;
        if ({bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2} !==
            {1'b1, 5'd3, 32'hF0F0_0000, 32'h0F0F_0001}) begin
            errors++;
            $display("FAIL rst_after_issue: got iv=%b op=%0d a=%h b=%h, required iv=1 op=3 a=f0f00000 b=0f0f0001",
                     bus.issue_valid, bus.aluop, bus.aluin1, bus.aluin2);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.res_rd, bus.res_illegal} !== {1'b1, 5'd17, 1'b0}) begin
            errors++;
            $display("FAIL rst_after_result: got rv=%b rd=%0d ill=%b, required rv=1 rd=17 ill=0",
                     bus.res_valid, bus.res_rd, bus.res_illegal);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_decode();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
